// File: rtl/reg_share_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_share_pkg: op codes and FSM states shared by the arbiter.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package reg_share_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Index width for a requester count; never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_share_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_share_arbiter_if: request/grant bundle of the shared register.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface reg_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic                     done;
  logic                     busy;
  logic [WIDTH-1:0]         reg_q;

  modport master (
    output req, op, wdata,
    input  gnt, done, busy, reg_q
  );

  modport slave (
    input  req, op, wdata,
    output gnt, done, busy, reg_q
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick starting at ptr.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int w_idx;

  // Scan from the farthest offset down so the nearest requester at or
  // above ptr is the last, and therefore final, assignment.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx = (int'(ptr) + off) % NUM_REQ;
      if (req[w_idx]) begin
        winner = IDX_W'(w_idx);
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_share_arbiter: round-robin access to one shared register.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int               NUM_REQ   = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  reg_share_arbiter_if.slave  bus
);

  localparam int               IDX_W      = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [IDX_W-1:0]   w_win;
  logic               w_valid;
  op_e                r_op;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_reg;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_done;
  logic               w_busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req    (bus.req),
    .ptr    (r_ptr),
    .winner (w_win),
    .valid  (w_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_valid) begin
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_gnt[r_win] = 1'b1;
        w_state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Snapshot the winner's request so later input activity cannot disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr  <= '0;
      r_win  <= '0;
      r_op   <= OP_LOAD;
      r_data <= '0;
    end else if (r_state == ST_IDLE && w_valid) begin
      r_win  <= w_win;
      r_op   <= op_e'(bus.op[2*w_win +: 2]);
      r_data <= bus.wdata[w_win*WIDTH +: WIDTH];
      r_ptr  <= (w_win == C_LAST_IDX) ? '0 : w_win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg <= RESET_VAL;
    end else if (r_state == ST_APPLY) begin
      case (r_op)
        OP_LOAD:   r_reg <= r_data;
        OP_SET:    r_reg <= '1;
        OP_CLEAR:  r_reg <= '0;
        OP_TOGGLE: r_reg <= ~r_reg;
        default:   r_reg <= r_reg;
      endcase
    end
  end

  assign bus.gnt   = w_gnt;
  assign bus.done  = w_done;
  assign bus.busy  = w_busy;
  assign bus.reg_q = r_reg;

endmodule
`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_share_arbiter: vector table, corner sequences, random run.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_reg_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  reg_share_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_reg;
  } vec_t;

  vec_t vt [8];

  bit [3:0]  m_req;
  bit [7:0]  m_opv;
  bit [31:0] m_wd;
  bit [7:0]  m_reg;
  bit [7:0]  m_exp;
  int        m_ptr;
  int        m_win;
  bit        m_found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Starts from IDLE with the inputs already driven; mode 0 holds inputs,
  // 1 drops req and zeroes wdata during APPLY, 2 scrambles everything.
  task automatic run_txn(input string tag, input logic [3:0] exp_gnt,
                         input logic [7:0] exp_reg, input int mode);
    tick();
    check({tag, " gnt"},  32'(bus.gnt),  32'(exp_gnt));
    check({tag, " busy1"}, 32'(bus.busy), 32'd1);
    check({tag, " done0"}, 32'(bus.done), 32'd0);
    if (mode == 1) begin
      bus.req   = '0;
      bus.wdata = '0;
      bus.op    = 8'($urandom);
    end else if (mode == 2) begin
      bus.req   = 4'($urandom);
      bus.op    = 8'($urandom);
      bus.wdata = $urandom;
    end
    tick();
    check({tag, " done"},  32'(bus.done),  32'd1);
    check({tag, " reg"},   32'(bus.reg_q), 32'(exp_reg));
    check({tag, " gnt0"},  32'(bus.gnt),   32'd0);
    tick();
    check({tag, " idle"},  32'(bus.busy),  32'd0);
    check({tag, " hold"},  32'(bus.reg_q), 32'(exp_reg));
  endtask

  initial begin
    vt[0] = '{4'b0001, 8'h00, 32'h000000A5, 4'b0001, 8'hA5};
    vt[1] = '{4'b0100, 8'h10, 32'h00000000, 4'b0100, 8'hFF};
    vt[2] = '{4'b0100, 8'h30, 32'h00000000, 4'b0100, 8'h00};
    vt[3] = '{4'b1000, 8'h00, 32'hF0000000, 4'b1000, 8'hF0};
    vt[4] = '{4'b1000, 8'h80, 32'h00000000, 4'b1000, 8'h00};
    vt[5] = '{4'b1010, 8'h00, 32'h55003C00, 4'b0010, 8'h3C};
    vt[6] = '{4'b1010, 8'h00, 32'h55003C00, 4'b1000, 8'h55};
    vt[7] = '{4'b0011, 8'h03, 32'h00001100, 4'b0001, 8'hAA};

    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst reg",  32'(bus.reg_q), 32'h00);
    check("rst gnt",  32'(bus.gnt),   32'h0);
    check("rst done", 32'(bus.done),  32'h0);
    check("rst busy", 32'(bus.busy),  32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("post-rst busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      bus.req   = vt[i].req;
      bus.op    = vt[i].op;
      bus.wdata = vt[i].wdata;
      run_txn($sformatf("vec%0d", i), vt[i].exp_gnt, vt[i].exp_reg, 1);
      if (i == 4) begin
        for (int c = 0; c < 6; c++) begin
          tick();
          check("idle busy", 32'(bus.busy),  32'd0);
          check("idle reg",  32'(bus.reg_q), 32'h00);
        end
      end
    end

    // All requesters held high, each loading its own index.
    do_reset();
    bus.req   = 4'hF;
    bus.op    = 8'h00;
    bus.wdata = 32'h03020100;
    for (int t = 0; t < 5; t++) begin
      run_txn($sformatf("rot%0d", t), 4'(1 << (t % 4)), 8'(t % 4), 0);
    end

    // Asynchronous reset in the middle of APPLY.
    do_reset();
    bus.req   = 4'b0001;
    bus.op    = 8'h00;
    bus.wdata = 32'h00000011;
    run_txn("pre-abort", 4'b0001, 8'h11, 1);
    bus.req   = 4'b0001;
    bus.wdata = 32'h00000077;
    tick();
    check("abort gnt pre", 32'(bus.gnt), 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort reg",  32'(bus.reg_q), 32'h00);
    check("abort gnt",  32'(bus.gnt),   32'h0);
    check("abort busy", 32'(bus.busy),  32'h0);
    tick();
    check("abort done", 32'(bus.done),  32'h0);
    check("abort reg2", 32'(bus.reg_q), 32'h00);
    reset_n   = 1'b1;
    bus.req   = 4'b0011;
    bus.op    = 8'h00;
    bus.wdata = 32'h00003322;
    run_txn("ptr-after-abort", 4'b0001, 8'h22, 1);

    // Randomised transactions against a transaction-level model.
    do_reset();
    m_reg = 8'h00;
    m_ptr = 0;
    for (int it = 0; it < 300; it++) begin
      m_req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      m_opv = 8'($urandom);
      m_wd  = $urandom;
      bus.req   = m_req;
      bus.op    = m_opv;
      bus.wdata = m_wd;
      if (m_req == 4'b0000) begin
        tick();
        check("rnd idle busy", 32'(bus.busy),  32'd0);
        check("rnd idle reg",  32'(bus.reg_q), 32'(m_reg));
      end else begin
        m_found = 1'b0;
        m_win   = 0;
        for (int off = 0; off < N; off++) begin
          if (!m_found && m_req[(m_ptr + off) % N]) begin
            m_found = 1'b1;
            m_win   = (m_ptr + off) % N;
          end
        end
        case (m_opv[2*m_win +: 2])
          2'b00:   m_exp = m_wd[8*m_win +: 8];
          2'b01:   m_exp = 8'hFF;
          2'b10:   m_exp = 8'h00;
          default: m_exp = ~m_reg;
        endcase
        run_txn($sformatf("rnd%0d", it), 4'(1 << m_win), m_exp, 2);
        m_reg = m_exp;
        m_ptr = (m_win + 1) % N;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the register, range 2..8.
REQ-002 Parameter WIDTH, default 8: width of the shared register.
REQ-003 Parameter RESET_VAL, default all-zeros: value of reg_q after reset.
REQ-004 clk  input  1: all state updates on the rising edge.
REQ-005 reset_n  input  1: reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ: per-requester access request, level.
REQ-007 op  input  2*NUM_REQ: per-requester operation code; requester i uses bits [2i+1:2i].
REQ-008 wdata  input  WIDTH*NUM_REQ: per-requester write data; requester i uses slice i.
REQ-009 gnt  output  NUM_REQ: one-hot grant, high during the APPLY cycle only.
REQ-010 done  output  1: one-cycle completion pulse, high during the DONE cycle.
REQ-011 busy  output  1: high whenever the state is not IDLE.
REQ-012 reg_q  output  WIDTH: current contents of the shared register.

Function
REQ-013 The FSM SHALL have three states: IDLE, APPLY and DONE.
REQ-014 IDLE SHALL go to APPLY on a rising edge when any req bit is high; otherwise it SHALL stay in IDLE.
REQ-015 APPLY SHALL go to DONE unconditionally; DONE SHALL go to IDLE unconditionally.
REQ-016 Winner selection SHALL be round-robin, starting the search at pointer ptr and moving upward with wrap (NUM_REQ-1 -> 0).
REQ-017 On the IDLE->APPLY edge, the winner index, its op and its wdata SHALL be captured into internal registers.
REQ-018 Input changes after the capture edge SHALL NOT affect the transaction in progress.
REQ-019 On the IDLE->APPLY edge, ptr SHALL become winner+1 modulo NUM_REQ; ptr reset value is 0.
REQ-020 gnt SHALL be the one-hot decode of the captured winner during APPLY and zero in every other state.
REQ-021 reg_q SHALL update on the APPLY->DONE edge according to the captured op:
  - 00 LOAD: captured wdata
  - 01 SET: all ones
  - 10 CLEAR: all zeros
  - 11 TOGGLE: bitwise invert of reg_q
REQ-022 reg_q SHALL hold its value on every other edge.
REQ-023 Latency: req sampled high at edge k gives gnt in cycle k+1, updated reg_q and done in cycle k+2, and IDLE again in cycle k+3.
REQ-024 Minimum transaction spacing SHALL be 3 cycles.
REQ-025 A req that falls during APPLY or DONE SHALL NOT abort the transaction; it SHALL complete normally.
REQ-026 A req still high in IDLE after its own DONE SHALL be arbitrated again with normal round-robin priority, with no special lockout.
REQ-027 When only one requester is active, it SHALL win every arbitration.
REQ-028 With all requests high, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no starvation; worst-case wait is NUM_REQ transactions.
REQ-029 The arbiter SHALL NOT modify reg_q except through a granted transaction.

Reset
REQ-030 While reset_n is low, state SHALL be IDLE, and ptr and the captured winner, op and data registers SHALL be 0.
REQ-031 While reset_n is low, outputs SHALL be: reg_q = RESET_VAL, gnt = 0, done = 0, busy = 0.
REQ-032 Reset asserted during APPLY or DONE SHALL abort the transaction immediately; no reg_q update and no done pulse are produced.
REQ-033 Deassertion SHALL be synchronised externally; the first arbitration is possible on the first rising edge after release.

Structure
REQ-034 A shared package reg_share_pkg SHALL hold the op encoding enum (OP_LOAD, OP_SET, OP_CLEAR, OP_TOGGLE) and the FSM state enum.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_arbiter with inputs req and ptr and outputs winner index and valid.
REQ-036 rr_arbiter SHALL be parameterised by NUM_REQ.
REQ-037 The shared register, the FSM and ptr SHALL reside in reg_share_arbiter.

Verification
REQ-038 Single LOAD: req=0001, op0=00, wdata0=0xA5 at edge k -> gnt=0001 in cycle k+1, reg_q=0xA5 and done=1 in cycle k+2, busy=0 in cycle k+3.
REQ-039 SET then TOGGLE from requester 2: reg_q 0x00 -> 0xFF -> 0x00; each transaction 3 cycles.
REQ-040 All four requests held high from reset, each with LOAD of its own index -> gnt sequence 0001, 0010, 0100, 1000, 0001; reg_q sequence 0,1,2,3,0.
REQ-041 Requester 1 drops req and changes wdata to 0x00 during APPLY with captured wdata 0x3C -> reg_q=0x3C and done still pulses.
REQ-042 reset_n asserted during APPLY of a LOAD 0x77 onto reg_q=0x11 -> reg_q=RESET_VAL, gnt=0, no done pulse, ptr=0, state IDLE.
REQ-043 CLEAR from requester 3 with reg_q=0xF0, followed by an idle period with no req -> reg_q=0x00 and remains stable; busy=0 for the whole idle period.
